// File: rtl/mux_scan.sv
// Registered N-channel selector: manual select by sel, or an automatic scan
// pass that dwells DWELL cycles on each channel and pulses done at the end.
module mux_scan #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 10,
  localparam int unsigned SELW    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      start,
  input  logic                      stop,
  output logic [WIDTH-1:0]          dout,
  output logic [SELW-1:0]           dout_sel,
  output logic                      valid,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned CNTW = $clog2(DWELL) + 1;
  localparam logic [SELW:0]   CH_COUNT = (SELW + 1)'(CHANNELS);
  localparam logic [SELW-1:0] CH_LAST  = SELW'(CHANNELS - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [SELW-1:0]   dsel_q, dsel_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [SELW-1:0]   src;
  logic [WIDTH-1:0]  src_data;
  logic              sel_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      dsel_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dsel_q  <= dsel_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dsel_d   = dsel_q;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    // One shared mux: the scan counter steers it while scanning, sel otherwise.
    src          = (state_q == SCAN) ? ch_q : sel;
    sel_in_range = ({1'b0, sel} < CH_COUNT);
    src_data     = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (src == SELW'(k)) src_data = din[k*WIDTH +: WIDTH];
    end

    unique case (state_q)
      IDLE: begin
        if (!mode) begin
          if (sel_in_range) begin
            dout_d  = src_data;
            dsel_d  = sel;
            valid_d = 1'b1;
          end
        end else if (start && !stop) begin
          state_d = SCAN;
          ch_d    = '0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          dout_d  = src_data;
          dsel_d  = ch_q;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (ch_q == CH_LAST) state_d = DONE;
            else                 ch_d    = ch_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout     = dout_q;
  assign dout_sel = dsel_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
